// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU select codes and
// controller state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_SEL_W = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MOD = 4'b1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channel between the two requesters and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
);
    logic [1:0]       in_req_valid;
    logic [1:0]       o_req_ready;
    logic [WIDTH-1:0] in_A0;
    logic [WIDTH-1:0] in_B0;
    logic [WIDTH-1:0] in_A1;
    logic [WIDTH-1:0] in_B1;
    logic [SEL_W-1:0] in_sel0;
    logic [SEL_W-1:0] in_sel1;
    logic [1:0]       o_rsp_valid;
    logic [1:0]       in_rsp_ready;
    logic [WIDTH-1:0] o_rsp_S;
    logic             o_rsp_zero;
    logic             o_rsp_err;

    modport master (
        output in_req_valid, in_A0, in_B0, in_A1, in_B1, in_sel0, in_sel1, in_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_S, o_rsp_zero, o_rsp_err
    );

    modport slave (
        input  in_req_valid, in_A0, in_B0, in_A1, in_B1, in_sel0, in_sel1, in_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_S, o_rsp_zero, o_rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: prio selects the winner when both request.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~prio | ~req[1]);
        gnt[1] = req[1] & ( prio | ~req[0]);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with
// round-robin arbitration and divide/modulo-by-zero flagging.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               SEL_W   = 4,
    parameter logic [SEL_W-1:0] DIV_SEL = SEL_W'(ALU_DIV),
    parameter logic [SEL_W-1:0] MOD_SEL = SEL_W'(ALU_MOD)
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] o_alu_A,
    output logic [WIDTH-1:0] o_alu_B,
    output logic [SEL_W-1:0] o_alu_sel,
    input  logic [WIDTH-1:0] in_alu_S,
    input  logic             in_alu_zero,
    output logic             o_busy
);

    logic [1:0]       state;
    logic             prio;
    logic             owner;
    logic [1:0]       gnt;
    logic             req_fire;
    logic             div_zero;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SEL_W-1:0] op_sel;
    logic [WIDTH-1:0] res_s;
    logic             res_zero;
    logic             res_err;

    rr_arb2 u_rr_arb2 (
        .req  (bus.in_req_valid),
        .prio (prio),
        .gnt  (gnt)
    );

    always_comb begin
        bus.o_req_ready = '0;
        bus.o_rsp_valid = '0;
        if (state == ST_IDLE)
            bus.o_req_ready = gnt;
        if (state == ST_RESP)
            bus.o_rsp_valid = owner ? 2'b10 : 2'b01;
    end

    always_comb begin
        req_fire = |(bus.in_req_valid & bus.o_req_ready);
        div_zero = ((op_sel == DIV_SEL) || (op_sel == MOD_SEL)) && (op_b == '0);
    end

    assign bus.o_rsp_S    = res_s;
    assign bus.o_rsp_zero = res_zero;
    assign bus.o_rsp_err  = res_err;
    assign o_alu_A        = op_a;
    assign o_alu_B        = op_b;
    assign o_alu_sel      = op_sel;
    assign o_busy         = (state != ST_IDLE);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= ST_IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            res_s    <= '0;
            res_zero <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        owner  <= gnt[1];
                        op_a   <= gnt[1] ? bus.in_A1   : bus.in_A0;
                        op_b   <= gnt[1] ? bus.in_B1   : bus.in_B0;
                        op_sel <= gnt[1] ? bus.in_sel1 : bus.in_sel0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // A zero divisor overrides whatever the ALU produced.
                    res_s    <= div_zero ? '0 : in_alu_S;
                    res_zero <= div_zero | in_alu_zero;
                    res_err  <= div_zero;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.in_rsp_ready[owner]) begin
                        prio  <= ~owner;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_s;
    logic        alu_zero;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_arbiter_if #(.WIDTH(32), .SEL_W(4)) bus ();

    alu_arbiter #(
        .WIDTH   (32),
        .SEL_W   (4),
        .DIV_SEL (4'b0011),
        .MOD_SEL (4'b1000)
    ) dut (
        .in_clk      (clk),
        .in_rst_n    (rst_n),
        .bus         (bus),
        .o_alu_A     (alu_a),
        .o_alu_B     (alu_b),
        .o_alu_sel   (alu_sel),
        .in_alu_S    (alu_s),
        .in_alu_zero (alu_zero),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divide/modulo by zero return junk so the arbiter's override is visible.
    always_comb begin
        alu_s = '0;
        case (alu_sel)
            ALU_ADD: alu_s = alu_a + alu_b;
            ALU_SUB: alu_s = alu_a - alu_b;
            ALU_MUL: alu_s = alu_a * alu_b;
            ALU_DIV: alu_s = (alu_b == 0) ? 32'hDEADBEEF : alu_a / alu_b;
            ALU_AND: alu_s = alu_a & alu_b;
            ALU_OR:  alu_s = alu_a | alu_b;
            ALU_XOR: alu_s = alu_a ^ alu_b;
            ALU_SLT: alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_MOD: alu_s = (alu_b == 0) ? 32'hBADC0DE1 : alu_a % alu_b;
            default: alu_s = '0;
        endcase
        alu_zero = (alu_s == 0);
    end

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  sel0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  sel1;
        logic [1:0]  gnt;
        logic [31:0] s;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_req_valid = '0;
        bus.in_rsp_ready = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  es;
        if (v.rst) do_reset();
        ea = v.gnt[1] ? v.a1 : v.a0;
        eb = v.gnt[1] ? v.b1 : v.b0;
        es = v.gnt[1] ? v.sel1 : v.sel0;
        bus.in_A0 = v.a0; bus.in_B0 = v.b0; bus.in_sel0 = v.sel0;
        bus.in_A1 = v.a1; bus.in_B1 = v.b1; bus.in_sel1 = v.sel1;
        bus.in_req_valid = v.valid;
        bus.in_rsp_ready = '0;
        #1;
        chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'(v.gnt));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        bus.in_req_valid = v.valid & ~v.gnt;
        chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
        chk({tag, "_exec_ready"}, 32'(bus.o_req_ready), 32'd0);
        chk({tag, "_alu_A"}, alu_a, ea);
        chk({tag, "_alu_B"}, alu_b, eb);
        chk({tag, "_alu_sel"}, 32'(alu_sel), 32'(es));
        @(posedge clk); #1;
        chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'(v.gnt));
        chk({tag, "_S"}, bus.o_rsp_S, v.s);
        chk({tag, "_zero"}, 32'(bus.o_rsp_zero), 32'(v.zero));
        chk({tag, "_err"}, 32'(bus.o_rsp_err), 32'(v.err));
        bus.in_rsp_ready = 2'b11;
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, 32'(bus.o_rsp_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        bus.in_rsp_ready = '0;
        bus.in_req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.in_req_valid = '0;
        bus.in_rsp_ready = '0;
        bus.in_A0 = '0; bus.in_B0 = '0; bus.in_sel0 = '0;
        bus.in_A1 = '0; bus.in_B1 = '0; bus.in_sel1 = '0;

        //          rst   valid  a0     b0     sel0      a1            b1     sel1     gnt    s         z     e
        vecs[0]  = '{1'b1, 2'b01, 32'd7,  32'd5, ALU_ADD,  32'd0,        32'd0, ALU_ADD, 2'b01, 32'd12,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 32'd9,  32'd9, ALU_SUB,  32'd3,        32'd4, ALU_MUL, 2'b01, 32'd0,    1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 32'd0,  32'd0, ALU_ADD,  32'd3,        32'd4, ALU_MUL, 2'b10, 32'd12,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 32'd10, 32'd0, ALU_DIV,  32'd0,        32'd0, ALU_ADD, 2'b01, 32'd0,    1'b1, 1'b1};
        vecs[4]  = '{1'b0, 2'b10, 32'd0,  32'd0, ALU_ADD,  32'd10,       32'd0, ALU_MOD, 2'b10, 32'd0,    1'b1, 1'b1};
        vecs[5]  = '{1'b0, 2'b01, 32'd10, 32'd3, ALU_DIV,  32'd0,        32'd0, ALU_ADD, 2'b01, 32'd3,    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b11, 32'd5,  32'd3, ALU_SUB,  32'hFFFFFFFF, 32'd1, ALU_ADD, 2'b10, 32'd0,    1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 32'd5,  32'd3, ALU_SUB,  32'hFFFFFFFF, 32'd1, ALU_ADD, 2'b01, 32'd2,    1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 32'd5,  32'd5, 4'b1111,  32'd0,        32'd0, ALU_ADD, 2'b01, 32'd0,    1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'b10, 32'd0,  32'd0, ALU_ADD,  32'hF0F0,     32'h0FF0, ALU_AND, 2'b10, 32'h00F0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 32'd17, 32'd5, ALU_MOD,  32'd0,        32'd0, ALU_ADD, 2'b01, 32'd2,    1'b0, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(bus.o_rsp_err), 32'd0);
        chk("rst_zero", 32'(bus.o_rsp_zero), 32'd0);
        chk("rst_alu_A", alu_a, 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run_txn(vecs[i], $sformatf("v%0d", i));

        // Both requesters held valid: grants must alternate from prio = 0.
        do_reset();
        bus.in_A0 = 32'd1; bus.in_B0 = 32'd1; bus.in_sel0 = ALU_ADD;
        bus.in_A1 = 32'd2; bus.in_B1 = 32'd2; bus.in_sel1 = ALU_ADD;
        bus.in_req_valid = 2'b11;
        bus.in_rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            while (bus.o_req_ready == 2'b00 && n < 5) begin
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("b2b%0d_timeout", k), 32'(n < 5), 32'd1);
            chk($sformatf("b2b%0d_gnt", k), 32'(bus.o_req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_S", k), bus.o_rsp_S, (k % 2 == 0) ? 32'd2 : 32'd4);
            @(posedge clk); #1;
        end
        bus.in_req_valid = '0;
        bus.in_rsp_ready = '0;
        @(posedge clk); #1;

        // Response backpressure; non-owner ready must not release it.
        bus.in_A0 = 32'd100; bus.in_B0 = 32'd23; bus.in_sel0 = ALU_SUB;
        bus.in_req_valid = 2'b01;
        bus.in_rsp_ready = 2'b10;
        #1;
        chk("bp_ready", 32'(bus.o_req_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_req_valid = 2'b10;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp%0d_valid", c), 32'(bus.o_rsp_valid), 32'd1);
            chk($sformatf("bp%0d_S", c), bus.o_rsp_S, 32'd77);
            chk($sformatf("bp%0d_flags", c), {30'd0, bus.o_rsp_zero, bus.o_rsp_err}, 32'd0);
            chk($sformatf("bp%0d_req_ready", c), 32'(bus.o_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_rsp_ready = 2'b01;
        @(posedge clk); #1;
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(bus.o_req_ready), 32'd2);
        bus.in_req_valid = '0;
        bus.in_rsp_ready = '0;
        @(posedge clk); #1;

        // Reset in EXEC aborts the operation.
        bus.in_A0 = 32'd6; bus.in_B0 = 32'd7; bus.in_sel0 = ALU_MUL;
        bus.in_req_valid = 2'b01;
        bus.in_rsp_ready = 2'b11;
        @(posedge clk); #1;
        bus.in_req_valid = '0;
        chk("abort_in_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_alu_A", alu_a, 32'd0);
        chk("abort_alu_B", alu_b, 32'd0);
        chk("abort_rsp_S", bus.o_rsp_S, 32'd0);
        chk("abort_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_after%0d_valid", c), 32'(bus.o_rsp_valid), 32'd0);
        end
        run_txn('{1'b0, 2'b01, 32'd6, 32'd7, ALU_MUL, 32'd0, 32'd0, ALU_ADD,
                  2'b01, 32'd42, 1'b0, 1'b0}, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters, for example the main datapath and a future coprocessor or address unit. The block accepts one operation at a time over a valid/ready request channel and chooses between requesters round-robin. It drives the ALU from registered operands, captures the result and Zero flag, and returns them over a valid/ready response channel to the requester that was granted. It also flags divide and modulo by zero instead of passing the ALU's undefined result through.

## Interface
Parameters:
- WIDTH, 32: operand and result width.
- SEL_W, 4: ALU function-select width.
- DIV_SEL, 4'b0011: select code for divide; triggers the zero-divisor check.
- MOD_SEL, 4'b1000: select code for modulo; triggers the zero-divisor check.

Ports:
- in_clk  input  1  single clock; all state updates on the rising edge.
- in_rst_n  input  1  reset; asynchronous and active-low.
- in_req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- o_req_ready  output  2  per-requester request ready; at most one bit is high.
- in_A0, in_B0 / in_A1, in_B1  input  WIDTH each  operands for requester 0 / requester 1.
- in_sel0 / in_sel1  input  SEL_W  ALU function for requester 0 / requester 1.
- o_rsp_valid  output  2  per-requester response valid; at most one bit is high.
- in_rsp_ready  input  2  per-requester response ready.
- o_rsp_S  output  WIDTH  result, shared by both requesters; qualified by o_rsp_valid.
- o_rsp_zero  output  1  Zero flag belonging to the result.
- o_rsp_err  output  1  operation was divide or modulo by zero.
- o_alu_A, o_alu_B  output  WIDTH  operands driven to the ALU.
- o_alu_sel  output  SEL_W  function select driven to the ALU.
- in_alu_S  input  WIDTH  ALU result.
- in_alu_zero  input  1  ALU Zero flag.
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
State machine, three states: IDLE, EXEC, RESP.

IDLE:
- The arbiter computes a one-hot grant from in_req_valid and a priority pointer, prio.
- prio = 0: requester 0 wins when both are valid. prio = 1: requester 1 wins.
- o_req_ready is the grant, asserted combinationally; it is 0 when no request is valid.
- On a handshake (valid & ready), latch A, B and sel into the operand register, latch the owner index, and go to EXEC.

EXEC:
- Lasts exactly one cycle.
- At the clock edge, capture in_alu_S and in_alu_zero into the result register, then go to RESP.
- Divide-by-zero: if sel is DIV_SEL or MOD_SEL and B = 0, capture S = 0, zero = 1, err = 1. Otherwise err = 0.

RESP:
- o_rsp_valid[owner] = 1.
- o_rsp_S, o_rsp_zero and o_rsp_err hold stable until in_rsp_ready[owner] = 1.
- On that handshake: go to IDLE and set prio to the index of the requester that was not served.
- in_rsp_ready on the non-owner bit is ignored.

ALU drive and width rules:
- o_alu_A, o_alu_B and o_alu_sel always reflect the operand register; they are not gated.
- Widths pass straight through; no sign handling is done in this block.

Fairness and unused codes:
- Round-robin guarantees that a requester held valid is served within 2 transactions.
- Select codes the ALU does not support are forwarded unchanged; the ALU returns 0 for them, so zero = 1.

## Timing
- Request handshake in cycle N.
- ALU is driven during cycle N+1.
- o_rsp_valid is high from cycle N+2 onward.
- Minimum issue interval is 3 cycles; o_req_ready is 0 in EXEC and RESP.
- Requester rule: a requester must hold its valid and operands until it receives ready. The arbiter may retarget its grant between cycles in IDLE if the valids change.

Reset (asynchronous, in_rst_n = 0):
- state = IDLE, prio = 0, owner = 0.
- Operand and result registers are 0.
- o_req_ready, o_rsp_valid, o_rsp_err and o_busy are 0; o_rsp_zero is 0.
- o_alu_A, o_alu_B and o_alu_sel are 0.
- Reset during EXEC or RESP aborts the operation: no response is issued and the result is lost.
- Release of reset is synchronous to in_clk through the registered state.

## Structure
- Shared package, alu_pkg:
  - ALU select codes: ADD 0000, SUB 0001, MUL 0010, DIV 0011, AND 0100, OR 0101, XOR 0110, SLT 0111, MOD 1000.
  - State encoding: IDLE, EXEC, RESP.
- One sub-module, rr_arb2: a 2-way round-robin grant (inputs req[1:0] and prio; output one-hot gnt). It is reusable by later shared-resource blocks.
- The ALU stays outside this block and connects via the o_alu_* / in_alu_* ports.

## Test plan
- Single request: requester 0 sends A = 7, B = 5, sel = ADD.
  - ready in cycle 0, o_busy in cycles 1–2.
  - o_rsp_valid[0] in cycle 2 with S = 12, zero = 0, err = 0.
- Simultaneous requests after reset: requester 0 sends SUB 9−9, requester 1 sends MUL 3·4.
  - Requester 0 is served first: S = 0, zero = 1.
  - Requester 1 is served next: S = 12; prio ends at 0.
- Back-to-back requesters kept valid for 6 transactions: grants alternate 0, 1, 0, 1, 0, 1.
- Divide by zero: DIV A = 10, B = 0, then MOD A = 10, B = 0.
  - Both return S = 0, zero = 1, err = 1.
  - DIV 10 / 3 returns S = 3, err = 0.
- Response backpressure: in_rsp_ready held 0 for 4 cycles.
  - o_rsp_S and flags stay stable; o_req_ready stays 0.
  - Release completes the transaction and returns to IDLE.
- Reset asserted during EXEC: outputs go to 0 immediately, with no o_rsp_valid afterward. The next request completes normally.
